// File: rtl/reg_writeback_unit_pkg.sv
// Shared sizing constants for the register writeback slice.
package reg_writeback_unit_pkg;
  localparam int WORD_WIDTH     = 16;
  localparam int REG_ADDR_WIDTH = 4;
  localparam int NUM_REGS       = 2 ** REG_ADDR_WIDTH;
  localparam int WB_FIFO_DEPTH  = 4;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/reg_writeback_unit_wb_fifo.sv
// Synchronous FIFO holding {rd, data} writeback entries; push ignored when full,
// pop ignored when empty.
module wb_fifo
  import reg_writeback_unit_pkg::*;
#(
  parameter int WIDTH = REG_ADDR_WIDTH + WORD_WIDTH,
  parameter int DEPTH = WB_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [WIDTH-1:0]              push_data,
  input  logic                          pop,
  output logic [WIDTH-1:0]              head_data,
  output logic                          full,
  output logic                          empty,
  output logic [count_width(DEPTH)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end
endmodule

// File: rtl/reg_writeback_unit.sv
// Register-file write front end: arbitrates ALU/load results into a writeback
// FIFO, drains one write per cycle, and stalls issue on pending destinations.
module reg_writeback_unit
  import reg_writeback_unit_pkg::*;
#(
  parameter int DATA_WIDTH     = WORD_WIDTH,
  parameter int REG_ADDR_WIDTH = reg_writeback_unit_pkg::REG_ADDR_WIDTH,
  parameter int FIFO_DEPTH     = WB_FIFO_DEPTH
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               alu_valid,
  input  logic [REG_ADDR_WIDTH-1:0]          alu_rd,
  input  logic [DATA_WIDTH-1:0]              alu_data,
  output logic                               alu_ready,
  input  logic                               mem_valid,
  input  logic [REG_ADDR_WIDTH-1:0]          mem_rd,
  input  logic [DATA_WIDTH-1:0]              mem_data,
  output logic                               mem_ready,
  input  logic                               issue_valid,
  input  logic [REG_ADDR_WIDTH-1:0]          issue_rd,
  input  logic [REG_ADDR_WIDTH-1:0]          issue_rs1,
  input  logic [REG_ADDR_WIDTH-1:0]          issue_rs2,
  output logic                               issue_stall,
  output logic                               rf_write_enable,
  output logic [REG_ADDR_WIDTH-1:0]          rf_dest,
  output logic [DATA_WIDTH-1:0]              rf_data,
  output logic [count_width(FIFO_DEPTH)-1:0] fifo_count,
  output logic                               err_unexpected
);
  localparam int NREGS = 2 ** REG_ADDR_WIDTH;
  localparam int EW    = REG_ADDR_WIDTH + DATA_WIDTH;

  logic                      full, empty;
  logic [EW-1:0]             head;
  logic                      mem_acc, alu_acc, push, pop;
  logic [REG_ADDR_WIDTH-1:0] acc_rd;
  logic [DATA_WIDTH-1:0]     acc_data;
  logic [NREGS-1:0]          pending_q, pending_d;
  logic                      err_q, err_d;

  // Handshakes: a producer transfers on a cycle where valid && ready; it holds
  // rd/data until then. Load results win; ready depends only on registered
  // FIFO occupancy, never on the same-cycle pop.
  always_comb begin
    mem_ready   = !reset && !full;
    alu_ready   = !reset && !full && !mem_valid;
    mem_acc     = mem_valid && mem_ready;
    alu_acc     = alu_valid && alu_ready;
    acc_rd      = mem_acc ? mem_rd : alu_rd;
    acc_data    = mem_acc ? mem_data : alu_data;
    push        = (mem_acc || alu_acc) && (acc_rd != '0);
    pop         = !reset && !empty;
    issue_stall = !reset && issue_valid &&
                  (pending_q[issue_rs1] || pending_q[issue_rs2] || pending_q[issue_rd]);
  end

  assign rf_write_enable   = pop;
  assign {rf_dest, rf_data} = head;
  assign err_unexpected    = err_q;

  // Clear on pop first so a same-register issue in the same cycle wins.
  always_comb begin
    pending_d = pending_q;
    if (pop) pending_d[rf_dest] = 1'b0;
    if (issue_valid && !issue_stall && (issue_rd != '0)) pending_d[issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
    err_d = err_q || (push && !pending_q[acc_rd]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  wb_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({acc_rd, acc_data}),
    .pop       (pop),
    .head_data (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );
endmodule
